// File: rtl/spdif_frame_sequencer.sv
// S/PDIF frame sequencer: buffers stereo sample pairs, emits left/right sub-frames with
// B/M/W preamble selection, channel-status (C) and user (U) bits, and mutes on source underrun.
module spdif_frame_sequencer #(
    parameter int unsigned audio_width  = 24,
    parameter int unsigned cs_width     = 40,
    parameter int unsigned block_frames = 192
) (
    input  logic                   clk128,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [audio_width-1:0] s_left,
    input  logic [audio_width-1:0] s_right,
    input  logic [cs_width-1:0]    cs_data,
    input  logic                   user_bit,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic                   o_is_frame_start,
    output logic                   o_is_left,
    output logic [audio_width-1:0] o_audio,
    output logic                   o_user,
    output logic                   o_control,
    output logic [7:0]             frame_index,
    output logic                   underrun
);

    localparam int unsigned IdxW      = 8;
    localparam logic [IdxW-1:0] LastFrame = IdxW'(block_frames - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEFT,
        ST_RIGHT
    } state_e;

    state_e                 state_q, state_d;

    logic                   buf_full_q, buf_full_d;
    logic [audio_width-1:0] buf_left_q, buf_left_d;
    logic [audio_width-1:0] buf_right_q, buf_right_d;
    logic                   buf_user_q, buf_user_d;

    logic [audio_width-1:0] frm_right_q, frm_right_d;
    logic [cs_width-1:0]    cs_q, cs_d;
    logic [IdxW-1:0]        idx_q, idx_d;

    logic                   s_ready_q, s_ready_d;
    logic                   valid_q, valid_d;
    logic                   fs_q, fs_d;
    logic                   left_q, left_d;
    logic [audio_width-1:0] audio_q, audio_d;
    logic                   user_q, user_d;
    logic                   ctl_q, ctl_d;
    logic                   underrun_q, underrun_d;

    logic                   xfer;
    logic [cs_width-1:0]    cs_shift;
    logic [audio_width-1:0] load_left;
    logic                   load_user;

    // State and datapath registers
    always_ff @(posedge clk128 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            buf_full_q  <= 1'b0;
            buf_left_q  <= '0;
            buf_right_q <= '0;
            buf_user_q  <= 1'b0;
            frm_right_q <= '0;
            cs_q        <= '0;
            idx_q       <= '0;
            s_ready_q   <= 1'b0;
            valid_q     <= 1'b0;
            fs_q        <= 1'b0;
            left_q      <= 1'b0;
            audio_q     <= '0;
            user_q      <= 1'b0;
            ctl_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_full_q  <= buf_full_d;
            buf_left_q  <= buf_left_d;
            buf_right_q <= buf_right_d;
            buf_user_q  <= buf_user_d;
            frm_right_q <= frm_right_d;
            cs_q        <= cs_d;
            idx_q       <= idx_d;
            s_ready_q   <= s_ready_d;
            valid_q     <= valid_d;
            fs_q        <= fs_d;
            left_q      <= left_d;
            audio_q     <= audio_d;
            user_q      <= user_d;
            ctl_q       <= ctl_d;
            underrun_q  <= underrun_d;
        end
    end

    // Next-state, sample buffer and sub-frame output logic
    always_comb begin
        state_d     = state_q;
        buf_full_d  = buf_full_q;
        buf_left_d  = buf_left_q;
        buf_right_d = buf_right_q;
        buf_user_d  = buf_user_q;
        frm_right_d = frm_right_q;
        cs_d        = cs_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        fs_d        = fs_q;
        left_d      = left_q;
        audio_d     = audio_q;
        user_d      = user_q;
        ctl_d       = ctl_q;
        underrun_d  = 1'b0;
        xfer        = valid_q & o_ready;
        cs_shift    = cs_q >> idx_q;
        load_left   = '0;
        load_user   = 1'b0;

        // s_ready_q already implies the buffer is empty, so this never races the LOAD drain
        if (s_valid && s_ready_q) begin
            buf_full_d  = 1'b1;
            buf_left_d  = s_left;
            buf_right_d = s_right;
            buf_user_d  = user_bit;
        end

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (enable) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    cs_d    = cs_data;
                end
            end
            ST_LOAD: begin
                if (buf_full_q) begin
                    load_left   = buf_left_q;
                    load_user   = buf_user_q;
                    frm_right_d = buf_right_q;
                    buf_full_d  = 1'b0;
                end else begin
                    frm_right_d = '0;
                    underrun_d  = 1'b1;
                end
                state_d = ST_LEFT;
                valid_d = 1'b1;
                left_d  = 1'b1;
                fs_d    = (idx_q == '0);
                audio_d = load_left;
                user_d  = load_user;
                ctl_d   = cs_shift[0];
            end
            ST_LEFT: begin
                if (xfer) begin
                    state_d = ST_RIGHT;
                    left_d  = 1'b0;
                    fs_d    = 1'b0;
                    audio_d = frm_right_q;
                end
            end
            ST_RIGHT: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    if (idx_q == LastFrame) begin
                        idx_d = '0;
                        cs_d  = cs_data;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                    if (enable) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        s_ready_d = !buf_full_d && (state_d != ST_IDLE);
    end

    assign s_ready          = s_ready_q;
    assign o_valid          = valid_q;
    assign o_is_frame_start = fs_q;
    assign o_is_left        = left_q;
    assign o_audio          = audio_q;
    assign o_user           = user_q;
    assign o_control        = ctl_q;
    assign frame_index      = idx_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_spdif_frame_sequencer.sv
// Directed bench for spdif_frame_sequencer: a sample source, a sub-frame expectation queue,
// and immediate assertions at every comparison point.
module tb_spdif_frame_sequencer;

    localparam int unsigned AW = 24;
    localparam int unsigned CW = 40;
    localparam int unsigned BF = 192;

    logic          clk128 = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_left;
    logic [AW-1:0] s_right;
    logic [CW-1:0] cs_data;
    logic          user_bit;
    logic          o_valid;
    logic          o_ready;
    logic          o_is_frame_start;
    logic          o_is_left;
    logic [AW-1:0] o_audio;
    logic          o_user;
    logic          o_control;
    logic [7:0]    frame_index;
    logic          underrun;

    always #5 clk128 = ~clk128;

    spdif_frame_sequencer #(
        .audio_width (AW),
        .cs_width    (CW),
        .block_frames(BF)
    ) dut (
        .clk128          (clk128),
        .reset_n         (reset_n),
        .enable          (enable),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_left          (s_left),
        .s_right         (s_right),
        .cs_data         (cs_data),
        .user_bit        (user_bit),
        .o_valid         (o_valid),
        .o_ready         (o_ready),
        .o_is_frame_start(o_is_frame_start),
        .o_is_left       (o_is_left),
        .o_audio         (o_audio),
        .o_user          (o_user),
        .o_control       (o_control),
        .frame_index     (frame_index),
        .underrun        (underrun)
    );

    typedef struct packed {
        logic [AW-1:0] l;
        logic [AW-1:0] r;
        logic          u;
    } smp_t;

    smp_t       q[$];
    smp_t       cur;
    int         checks      = 0;
    int         errors      = 0;
    int         ur_cnt      = 0;
    int         frames_done = 0;
    int         force_mute  = 0;
    int         src_n       = 0;
    int         src_limit   = 0;
    int         fs_seen     = 0;
    int         ctl_seen    = 0;
    logic       exp_left    = 1'b1;
    logic [7:0] exp_frame   = 8'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] lv(input int n);
        return (n == 0) ? 24'h123456 : AW'(32'h100000 + n);
    endfunction

    function automatic logic [AW-1:0] rv(input int n);
        return (n == 0) ? 24'hABCDEF : AW'(32'h800000 + n);
    endfunction

    task automatic drive_src();
        s_valid  = (src_n < src_limit);
        s_left   = lv(src_n);
        s_right  = rv(src_n);
        user_bit = 1'(src_n & 1);
    endtask

    // One clock: score any sub-frame transfer, advance, then track source acceptance and underrun
    task automatic step();
        logic          acc;
        logic          xfer;
        logic          en_pre;
        logic          ctl_e;
        logic [CW-1:0] csh;
        logic [35:0]   obs;
        logic [35:0]   expv;
        smp_t          t;
        acc    = s_valid && s_ready;
        xfer   = o_valid && o_ready;
        en_pre = enable;
        if (xfer) begin
            obs   = {o_audio, frame_index, o_is_frame_start, o_is_left, o_control, o_user};
            csh   = cs_data >> exp_frame;
            ctl_e = csh[0];
            if (exp_left) begin
                if (force_mute > 0) begin
                    cur = '0;
                    force_mute--;
                end else if (q.size() == 0) begin
                    cur = '0;
                end else begin
                    cur = q.pop_front();
                end
                expv = {cur.l, exp_frame, exp_frame == 8'd0, 1'b1, ctl_e, cur.u};
                check("left_subframe", 64'(obs), 64'(expv));
            end else begin
                expv = {cur.r, exp_frame, 1'b0, 1'b0, ctl_e, cur.u};
                check("right_subframe", 64'(obs), 64'(expv));
                frames_done++;
                if (!en_pre || exp_frame == 8'(BF - 1)) exp_frame = 8'd0;
                else exp_frame = exp_frame + 8'd1;
            end
            fs_seen  += int'(o_is_frame_start);
            ctl_seen += int'(o_control);
            exp_left = !exp_left;
        end
        @(posedge clk128);
        #1;
        if (underrun) ur_cnt++;
        if (acc) begin
            t.l = s_left;
            t.r = s_right;
            t.u = user_bit;
            q.push_back(t);
            src_n++;
            drive_src();
        end
    endtask

    task automatic run_frames(input int n);
        int target;
        int budget;
        target = frames_done + n;
        budget = 0;
        while (frames_done < target && budget < 10 * n + 20) begin
            step();
            budget++;
        end
        check("run_frames_done", 64'(frames_done), 64'(target));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        o_ready  = 1'b0;
        cs_data  = '0;
        drive_src();
        repeat (3) @(posedge clk128);
        #1;
        check("reset_s_ready", 64'(s_ready), 64'd0);
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_frame_index", 64'(frame_index), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        check("reset_o_audio", 64'(o_audio), 64'd0);
        check("reset_flags", 64'({o_is_frame_start, o_is_left, o_control, o_user}), 64'd0);
        reset_n = 1'b1;
        step();

        // First frame after reset is muted (nothing could be buffered in IDLE); the pair
        // presented then is buffered, survives IDLE and leads the next block with B.
        cs_data    = 40'h4;
        o_ready    = 1'b1;
        force_mute = 1;
        src_limit  = 1;
        drive_src();
        enable = 1'b1;
        step();
        step();
        enable = 1'b0;
        step();
        step();
        check("idle_o_valid", 64'(o_valid), 64'd0);
        check("idle_s_ready", 64'(s_ready), 64'd0);
        check("idle_frame_index", 64'(frame_index), 64'd0);
        check("first_underrun_count", 64'(ur_cnt), 64'd1);

        // Stream frames 0..386: B at 0/192/384, C at 2/194/386 on both sub-frames
        fs_seen   = 0;
        ctl_seen  = 0;
        src_limit = 388;
        drive_src();
        enable = 1'b1;
        run_frames(387);
        check("stream_fs_count", 64'(fs_seen), 64'd3);
        check("stream_ctl_count", 64'(ctl_seen), 64'd6);
        check("stream_underruns", 64'(ur_cnt), 64'd1);

        // Encoder back-pressure on frame 387 left (index 3)
        o_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_hold",
                  64'({o_valid, o_audio, frame_index, o_is_frame_start, o_is_left, o_control, o_user}),
                  64'({1'b1, lv(387), 8'd3, 1'b0, 1'b1, 1'b0, 1'b1}));
        end
        o_ready = 1'b1;
        run_frames(1);

        // Source dry: frames 388/389 muted, one pulse each
        run_frames(2);
        check("underrun_two_muted", 64'(ur_cnt), 64'd3);

        // Sample offered during LOAD is too late: frame 390 muted, it goes to frame 391
        force_mute = 1;
        src_limit  = src_n + 6;
        drive_src();
        run_frames(1);
        run_frames(2);
        check("underrun_resume", 64'(ur_cnt), 64'd4);

        // Drop enable during LEFT of frame 393: RIGHT still completes, then IDLE
        step();
        enable = 1'b0;
        step();
        step();
        step();
        check("drop_o_valid", 64'(o_valid), 64'd0);
        check("drop_s_ready", 64'(s_ready), 64'd0);
        check("drop_frame_index", 64'(frame_index), 64'd0);
        src_limit = src_n;
        drive_src();
        enable = 1'b1;
        run_frames(1);
        check("restart_no_pulse", 64'(ur_cnt), 64'd4);

        // Async reset while RIGHT of frame 1 is stalled
        step();
        step();
        o_ready = 1'b0;
        step();
        check("pre_reset_o_valid", 64'(o_valid), 64'd1);
        check("pre_reset_frame_index", 64'(frame_index), 64'd1);
        check("pre_reset_s_ready", 64'(s_ready), 64'd1);
        check("pre_reset_underruns", 64'(ur_cnt), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_o_valid", 64'(o_valid), 64'd0);
        check("async_s_ready", 64'(s_ready), 64'd0);
        check("async_frame_index", 64'(frame_index), 64'd0);
        check("async_o_audio", 64'(o_audio), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
